// File: rtl/afifo_pkg.sv
// Shared types and constants for the async FIFO traffic generators and checkers.
package afifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wgen_state_e;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2
    } wgen_mode_e;

    // x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/afifo_wgen_pattern.sv
// Data pattern function: produces either the first word of a burst (first=1)
// or the word that follows 'word' in the selected mode. Shared with the read-side checker.
module afifo_wgen_pattern
    import afifo_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic                  first,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] next_word
);

    // An all-zero LFSR state never leaves zero, so a zero seed is bumped to 1.
    always_comb begin
        next_word = word + DATA_WIDTH'(1);
        if (first) begin
            if (mode == MODE_LFSR && word == '0) begin
                next_word = DATA_WIDTH'(1);
            end else begin
                next_word = word;
            end
        end else begin
            case (mode)
                MODE_CONST: next_word = word;
                MODE_LFSR:  next_word = {word[DATA_WIDTH-2:0], ^(word & LFSR_TAPS)};
                default:    next_word = word + DATA_WIDTH'(1);
            endcase
        end
    end

endmodule

// File: rtl/afifo_wgen.sv
// Write-side burst traffic generator for the async FIFO: one command at a time,
// full back-pressure on wfull, saturating word and stall counters.
module afifo_wgen
    import afifo_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    LEN_WIDTH  = ADDR_WIDTH + 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic [1:0]            cmd_mode,
    input  logic                  abort,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wfull,
    output logic                  busy,
    output logic                  done,
    output logic                  done_aborted,
    output logic [31:0]           words_written,
    output logic [31:0]           stall_cycles
);

    wgen_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [1:0]            mode_q, mode_d;

    logic                  winc_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  done_aborted_d;
    logic [31:0]           words_d;
    logic [31:0]           stall_d;

    logic                  handshake;
    logic                  accept;
    logic                  last_accept;
    logic                  pat_first;
    logic [1:0]            pat_mode;
    logic [DATA_WIDTH-1:0] pat_word_in;
    logic [DATA_WIDTH-1:0] pat_word;

    assign cmd_ready   = (state_q == IDLE);
    assign handshake   = cmd_valid && (state_q == IDLE);
    assign accept      = (state_q == WRITE) && winc && !wfull;
    assign last_accept = accept && (remaining_q == LEN_WIDTH'(1));

    // In IDLE the pattern unit fixes up the incoming seed; otherwise it advances wdata.
    assign pat_first   = (state_q == IDLE);
    assign pat_mode    = pat_first ? cmd_mode : mode_q;
    assign pat_word_in = pat_first ? cmd_seed : wdata;

    afifo_wgen_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_TAPS  (LFSR_TAPS)
    ) u_pattern (
        .first     (pat_first),
        .mode      (pat_mode),
        .word      (pat_word_in),
        .next_word (pat_word)
    );

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_len != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (abort || last_accept) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of every registered output; a completing last word beats a coincident abort.
    always_comb begin
        winc_d         = (state_d == WRITE);
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
        done_aborted_d = (state_q == WRITE) && abort && !last_accept;
        wdata_d        = wdata;
        remaining_d    = remaining_q;
        mode_d         = mode_q;
        words_d        = words_written;
        stall_d        = stall_cycles;

        if (handshake) begin
            mode_d      = cmd_mode;
            remaining_d = cmd_len;
            if (cmd_len != '0) begin
                wdata_d = pat_word;
            end
        end else if (accept) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
            wdata_d     = pat_word;
        end

        if (accept && words_written != 32'hFFFF_FFFF) begin
            words_d = words_written + 32'd1;
        end
        if (winc && wfull && stall_cycles != 32'hFFFF_FFFF) begin
            stall_d = stall_cycles + 32'd1;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            winc          <= 1'b0;
            wdata         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            done_aborted  <= 1'b0;
            remaining_q   <= '0;
            mode_q        <= 2'd0;
            words_written <= '0;
            stall_cycles  <= '0;
        end else begin
            winc          <= winc_d;
            wdata         <= wdata_d;
            busy          <= busy_d;
            done          <= done_d;
            done_aborted  <= done_aborted_d;
            remaining_q   <= remaining_d;
            mode_q        <= mode_d;
            words_written <= words_d;
            stall_cycles  <= stall_d;
        end
    end

endmodule

// File: tb/tb_afifo_wgen.sv
// Directed self-checking bench for afifo_wgen: bursts, back-pressure, wrap, LFSR, abort, async reset.
module tb_afifo_wgen;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic [1:0]    cmd_mode = 2'd0;
    logic          abort = 1'b0;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          wfull = 1'b0;
    logic          busy;
    logic          done;
    logic          done_aborted;
    logic [31:0]   words_written;
    logic [31:0]   stall_cycles;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [31:0]   fifo_q[$];

    afifo_wgen dut (
        .wclk          (wclk),
        .wrst          (wrst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .cmd_mode      (cmd_mode),
        .abort         (abort),
        .winc          (winc),
        .wdata         (wdata),
        .wfull         (wfull),
        .busy          (busy),
        .done          (done),
        .done_aborted  (done_aborted),
        .words_written (words_written),
        .stall_cycles  (stall_cycles)
    );

    always #5 wclk = ~wclk;

    // Models the FIFO side: captures every word accepted at a write edge.
    always @(posedge wclk) begin
        if (!wrst && winc && !wfull) begin
            fifo_q.push_back(wdata);
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkWrite(input string tag, input logic [31:0] exp_data);
        checkOutput({tag, " winc"}, {31'd0, winc}, 32'd1);
        checkOutput({tag, " wdata"}, wdata, exp_data);
    endtask

    task automatic applyStimulus(input logic v, input logic [LW-1:0] len,
                                 input logic [DW-1:0] seed, input logic [1:0] mode);
        cmd_valid = v;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_mode  = mode;
    endtask

    initial begin
        $display("[TB] start");
        tick();
        tick();
        wrst = 1'b0;
        tick();

        checkOutput("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst busy", {31'd0, busy}, 32'd0);
        checkOutput("rst winc", {31'd0, winc}, 32'd0);
        checkOutput("rst wdata", wdata, 32'd0);
        checkOutput("rst done", {31'd0, done}, 32'd0);
        checkOutput("rst words", words_written, 32'd0);
        checkOutput("rst stalls", stall_cycles, 32'd0);

        // Increment burst of 4
        applyStimulus(1'b1, 16'd4, 32'h10, 2'd0);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkOutput("inc busy", {31'd0, busy}, 32'd1);
        checkOutput("inc cmd_ready", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkWrite("inc", 32'h10 + 32'(i));
            checkOutput("inc no done", {31'd0, done}, 32'd0);
            tick();
        end
        checkOutput("inc end winc", {31'd0, winc}, 32'd0);
        checkOutput("inc done", {31'd0, done}, 32'd1);
        checkOutput("inc done_aborted", {31'd0, done_aborted}, 32'd0);
        checkOutput("inc busy in done", {31'd0, busy}, 32'd1);
        checkOutput("inc words", words_written, 32'd4);
        tick();
        checkOutput("inc done pulse", {31'd0, done}, 32'd0);
        checkOutput("inc idle", {31'd0, cmd_ready}, 32'd1);

        // Back-pressure: wfull high during burst cycles 2-4
        fifo_q.delete();
        applyStimulus(1'b1, 16'd3, 32'hA0, 2'd0);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkWrite("bp c1", 32'hA0);
        tick();
        wfull = 1'b1;
        checkWrite("bp c2", 32'hA1);
        tick();
        checkWrite("bp c3", 32'hA1);
        tick();
        checkWrite("bp c4", 32'hA1);
        tick();
        wfull = 1'b0;
        checkWrite("bp c5", 32'hA1);
        tick();
        checkWrite("bp c6", 32'hA2);
        tick();
        checkOutput("bp done", {31'd0, done}, 32'd1);
        checkOutput("bp winc", {31'd0, winc}, 32'd0);
        checkOutput("bp stalls", stall_cycles, 32'd3);
        checkOutput("bp words", words_written, 32'd7);
        checkOutput("bp fifo count", 32'(fifo_q.size()), 32'd3);
        if (fifo_q.size() == 3) begin
            checkOutput("bp fifo w0", fifo_q[0], 32'hA0);
            checkOutput("bp fifo w1", fifo_q[1], 32'hA1);
            checkOutput("bp fifo w2", fifo_q[2], 32'hA2);
        end
        tick();

        // Zero-length command
        applyStimulus(1'b1, 16'd0, 32'h55, 2'd0);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkOutput("zero winc", {31'd0, winc}, 32'd0);
        checkOutput("zero done", {31'd0, done}, 32'd1);
        checkOutput("zero done_aborted", {31'd0, done_aborted}, 32'd0);
        checkOutput("zero cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        checkOutput("zero idle", {31'd0, cmd_ready}, 32'd1);

        // Increment wraps at the data width
        applyStimulus(1'b1, 16'd2, 32'hFFFF_FFFF, 2'd0);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkWrite("wrap w0", 32'hFFFF_FFFF);
        tick();
        checkWrite("wrap w1", 32'h0000_0000);
        tick();
        checkOutput("wrap done", {31'd0, done}, 32'd1);
        checkOutput("wrap words", words_written, 32'd9);
        tick();

        // LFSR with zero seed: 1, then {1,parity(1&taps)=1}=3, then {3<<1,parity(3&taps)=0}=6
        applyStimulus(1'b1, 16'd3, 32'h0, 2'd2);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkWrite("lfsr w0", 32'h1);
        tick();
        checkWrite("lfsr w1", 32'h3);
        tick();
        checkWrite("lfsr w2", 32'h6);
        tick();
        checkOutput("lfsr done", {31'd0, done}, 32'd1);
        checkOutput("lfsr words", words_written, 32'd12);
        tick();

        // Abort coincident with 3rd accept, constant mode
        fifo_q.delete();
        applyStimulus(1'b1, 16'd10, 32'h200, 2'd1);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkWrite("abort c1", 32'h200);
        tick();
        checkWrite("abort c2", 32'h200);
        tick();
        abort = 1'b1;
        checkWrite("abort c3", 32'h200);
        tick();
        abort = 1'b0;
        checkOutput("abort winc", {31'd0, winc}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd1);
        checkOutput("abort done_aborted", {31'd0, done_aborted}, 32'd1);
        checkOutput("abort words", words_written, 32'd15);
        checkOutput("abort fifo count", 32'(fifo_q.size()), 32'd3);
        tick();
        checkOutput("abort ready after", {31'd0, cmd_ready}, 32'd1);
        checkOutput("abort busy after", {31'd0, busy}, 32'd0);
        checkOutput("abort done_aborted clr", {31'd0, done_aborted}, 32'd0);

        // Abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("idle abort busy", {31'd0, busy}, 32'd0);
        checkOutput("idle abort done", {31'd0, done}, 32'd0);

        // Abort on the final accept completes normally
        applyStimulus(1'b1, 16'd2, 32'h5, 2'd3);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkWrite("lastab w0", 32'h5);
        tick();
        abort = 1'b1;
        checkWrite("lastab w1", 32'h6);
        tick();
        abort = 1'b0;
        checkOutput("lastab done", {31'd0, done}, 32'd1);
        checkOutput("lastab done_aborted", {31'd0, done_aborted}, 32'd0);
        checkOutput("lastab words", words_written, 32'd17);
        tick();

        // Asynchronous reset between clock edges during WRITE
        applyStimulus(1'b1, 16'd8, 32'h50, 2'd0);
        tick();
        applyStimulus(1'b0, 16'd0, 32'h0, 2'd0);
        checkWrite("areset w0", 32'h50);
        tick();
        checkWrite("areset w1", 32'h51);
        #2;
        wrst = 1'b1;
        #1;
        checkOutput("areset winc", {31'd0, winc}, 32'd0);
        checkOutput("areset wdata", wdata, 32'd0);
        checkOutput("areset words", words_written, 32'd0);
        tick();
        tick();
        wrst = 1'b0;
        tick();
        checkOutput("post busy", {31'd0, busy}, 32'd0);
        checkOutput("post cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("post words", words_written, 32'd0);
        checkOutput("post stalls", stall_cycles, 32'd0);
        checkOutput("post winc", {31'd0, winc}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
